reg_file_scan_reader: RTL and testbench
=======================================

# reg_file_scan_reader

Read-side companion to the 32×32 register file on the board top. On a start request it sweeps a configurable address range, issues one read per address and presents each `{address, data}` pair downstream on a valid/ready handshake. The downstream consumer is the 7-segment display driver or a debug dump path. It replaces manual switch-driven inspection of register contents after a write/ALU/write-back sequence.

## Interface
Parameters:
- `ADDR_W`, 5, register address width.
- `DATA_W`, 32, register data width.
- `FIRST_ADDR`, 0, first address swept.
- `LAST_ADDR`, 31, last address swept. `FIRST_ADDR <= LAST_ADDR` is required.

Ports:
- `clk`  in  1  single clock. All logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level-sampled. Begins a sweep when idle.
- `abort`  in  1  level-sampled. Cancels a sweep in progress.
- `rd_en`  out  1  read strobe to the register file.
- `rd_addr`  out  ADDR_W  read address to the register file.
- `rd_data`  in  DATA_W  register file read data. It is valid the cycle after the edge that samples `rd_en`/`rd_addr`.
- `out_valid`  out  1  an entry is presented.
- `out_ready`  in  1  the consumer accepts the entry.
- `out_addr`  out  ADDR_W  address of the presented entry.
- `out_data`  out  DATA_W  data of the presented entry.
- `busy`  out  1  a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes normally.
- `checksum`  out  DATA_W  sweep checksum (see Configuration).

## Operation
- The FSM has five states: IDLE, ADDR, WAIT, PRESENT, DONE.
- **IDLE:** `busy`=0.
  - `start`=1 → ADDR, with `rd_addr`=FIRST_ADDR and the checksum cleared.
- **ADDR:** `rd_en`=1 → WAIT.
- **WAIT:** `rd_en`=0. Capture `rd_data` into `out_data` and `rd_addr` into `out_addr`, then → PRESENT.
- **PRESENT:** `out_valid`=1. `out_addr` and `out_data` stay stable until the handshake.
  - Handshake (`out_valid & out_ready` at an edge) with `rd_addr`==LAST_ADDR → DONE.
  - Handshake with any other address → `rd_addr`+1, then → ADDR.
- **DONE:** `done`=1 for exactly one cycle → IDLE.
- `start` in any state other than IDLE is ignored. Sweeps never restart or overlap.
- `abort`=1 in any non-IDLE state → IDLE at the next edge.
  - Clears `out_valid`, `rd_en` and `busy`.
  - No `done` pulse. `checksum` holds its partial value.
- Priority at an edge: `rst` > `abort` > `start`/handshake.
- `rd_addr` never increments past LAST_ADDR. There is no wrap within a sweep.
- `FIRST_ADDR`==`LAST_ADDR` gives a single-entry sweep.

## Timing
- All outputs are registered.
- Reset values: every output is 0, and the state is IDLE.
- `start` sampled at edge N:
  - `rd_en` is high during cycle N..N+1.
  - `out_valid` is high after edge N+2.
- With `out_ready` held at 1, throughput is 3 cycles per entry.
- Full default sweep with `out_ready`=1:
  - last handshake at edge N+96;
  - `done` high after N+96;
  - IDLE after N+97.
- Back-pressure: each cycle of `out_ready`=0 in PRESENT adds one cycle. Nothing is dropped or duplicated.
- `rst` asserted mid-sweep returns to IDLE with all outputs 0 at that edge. No `done` pulse.

## Configuration
- Macro `REGSCAN_CHECKSUM_EN`.
- Defined: `checksum` accumulates `out_data` modulo 2^DATA_W on each handshake.
  - It is cleared on sweep start and on `rst`.
  - It is final when `done` pulses.
- Undefined: `checksum` is constant 0, with no accumulator logic. The port list is unchanged.

## Structure
- Package `regscan_pkg` holds:
  - the state enum (IDLE/ADDR/WAIT/PRESENT/DONE);
  - `ADDR_W`/`DATA_W` defaults;
  - default FIRST/LAST address constants.
- Sub-module `regscan_addr_ctr` is the loadable address counter. It provides load-FIRST, increment, and an `at_last` flag.
- FSM, capture registers and checksum live in the top module.

## Test plan
- Reset: `rst`=1 for 2 cycles mid-sweep → all outputs 0 at the next edge, state IDLE, no `done`.
- Full sweep with `out_ready`=1 and model regs[i]=`32'h1000_0000+i`:
  - 32 entries in address order 0..31, each with `out_data` = `32'h1000_0000+i`;
  - `done` pulses once, 96 cycles after the edge that sampled `start`.
- Back-pressure: `out_ready` toggled in the pattern 0,0,1 → each entry held stable for exactly 3 PRESENT cycles, and no duplicate addresses.
- Abort with `abort`=1 while presenting address 5 → IDLE next edge, `busy`=0, `done` never asserted.
  - A new `start` then sweeps from 0 again.
- Ignored start: `start` held high for the whole sweep → exactly one sweep.
  - A new sweep begins on the edge after the DONE→IDLE transition if `start` is still high.
- With `REGSCAN_CHECKSUM_EN`, FIRST=1, LAST=4, regs 1..4 = `32'hFFFF_FFFF`,1,2,3:
  - `checksum`=`32'h0000_0005` at `done`.
  - Without the macro, `checksum`=0 throughout.

Source files
------------

// File: rtl/regscan_pkg.sv
// Shared types and default geometry for the register-file scan reader.
package regscan_pkg;

  localparam int REGSCAN_ADDR_W     = 5;
  localparam int REGSCAN_DATA_W     = 32;
  localparam int REGSCAN_FIRST_ADDR = 0;
  localparam int REGSCAN_LAST_ADDR  = 31;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } regscan_state_e;

endpackage

// File: rtl/reg_file_scan_reader_if.sv
// Control, register-file read and downstream entry signals of the scan reader.
// The scanner drives the master modport; the register file / consumer side uses slave.
interface reg_file_scan_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              abort;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, abort, rd_data, out_ready,
    output rd_en, rd_addr, out_valid, out_addr, out_data, busy, done, checksum
  );

  modport slave (
    output start, abort, rd_data, out_ready,
    input  rd_en, rd_addr, out_valid, out_addr, out_data, busy, done, checksum
  );
endinterface

// File: rtl/regscan_addr_ctr.sv
// Loadable sweep address counter: load-first, saturating increment, at-last flag.
module regscan_addr_ctr #(
  parameter int ADDR_W     = 5,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_at_last
);
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

  logic [ADDR_W-1:0] r_addr;
  logic              w_at_last;

  assign w_at_last = (r_addr == LAST_A);

  // Increment stops at the last address, so a sweep can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= FIRST_A;
    end else if (i_inc && !w_at_last) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr    = r_addr;
  assign o_at_last = w_at_last;
endmodule

// File: rtl/reg_file_scan_reader.sv
// Sweeps a register-file address range and presents each {addr,data} on valid/ready.
// Define REGSCAN_CHECKSUM_EN to accumulate a modulo-2^DATA_W checksum of accepted data.
module reg_file_scan_reader
  import regscan_pkg::*;
#(
  parameter int ADDR_W     = REGSCAN_ADDR_W,
  parameter int DATA_W     = REGSCAN_DATA_W,
  parameter int FIRST_ADDR = REGSCAN_FIRST_ADDR,
  parameter int LAST_ADDR  = REGSCAN_LAST_ADDR
) (
  input logic                    clk,
  input logic                    rst,
  reg_file_scan_reader_if.master bus
);
  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_ADDR    = ST_ADDR;
  localparam logic [2:0] S_WAIT    = ST_WAIT;
  localparam logic [2:0] S_PRESENT = ST_PRESENT;
  localparam logic [2:0] S_DONE    = ST_DONE;

  logic [2:0]        r_state;
  logic              r_rd_en;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;

  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_at_last;
  logic              w_abort;
  logic              w_start;
  logic              w_hs;
  logic              w_inc;

  // Abort outranks both a new start and a pending handshake.
  assign w_abort = bus.abort && (r_state != S_IDLE);
  assign w_start = bus.start && !bus.abort && (r_state == S_IDLE);
  assign w_hs    = (r_state == S_PRESENT) && bus.out_ready && !bus.abort;
  assign w_inc   = w_hs && !w_at_last;

  regscan_addr_ctr #(
    .ADDR_W    (ADDR_W),
    .FIRST_ADDR(FIRST_ADDR),
    .LAST_ADDR (LAST_ADDR)
  ) u_addr_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_start),
    .i_inc    (w_inc),
    .o_addr   (w_rd_addr),
    .o_at_last(w_at_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rd_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else if (w_abort) begin
      r_state     <= S_IDLE;
      r_rd_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_ADDR;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_ADDR: begin
          r_state <= S_WAIT;
          r_rd_en <= 1'b0;
        end
        S_WAIT: begin
          // Read data is valid now, one cycle after the strobe was sampled.
          r_out_addr  <= w_rd_addr;
          r_out_data  <= bus.rd_data;
          r_out_valid <= 1'b1;
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            if (w_at_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ADDR;
              r_rd_en <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef REGSCAN_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Partial sum is kept on abort; only reset or a new sweep clears it.
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_checksum <= '0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + r_out_data;
    end
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = w_rd_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_reg_file_scan_reader.sv
// Self-checking bench for reg_file_scan_reader; expected checksum follows REGSCAN_CHECKSUM_EN.
module tb_reg_file_scan_reader;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] regs [0:31];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_file_scan_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  reg_file_scan_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  reg_file_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .FIRST_ADDR(0), .LAST_ADDR(31)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  reg_file_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .FIRST_ADDR(1), .LAST_ADDR(4)) dut_small (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // Register file stand-ins: registered read, data valid the cycle after the strobe.
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= regs[bus.rd_addr];
  always @(posedge clk) if (bus2.rd_en) bus2.rd_data <= regs[bus2.rd_addr];

  function automatic logic [DW-1:0] exp_sum(input logic [DW-1:0] s);
`ifdef REGSCAN_CHECKSUM_EN
    return s;
`else
    return '0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int found;
    int bad;
    repeat (2) step();
    checks++;
    if ({bus.rd_en, bus.out_valid, bus.busy, bus.done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: rd_en/valid/busy/done=%b required 0000", {bus.rd_en, bus.out_valid, bus.busy, bus.done});
    end
    checks++;
    if (bus.rd_addr !== '0 || bus.out_addr !== '0 || bus.out_data !== '0 || bus.checksum !== '0) begin
      errors++;
      $display("FAIL reset_values: rd_addr=%0d out_addr=%0d out_data=%h checksum=%h required all 0",
               bus.rd_addr, bus.out_addr, bus.out_data, bus.checksum);
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (bus.out_valid && bus.out_addr == 5'd3) found = 1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_reach: addr 3 not presented within 60 cycles, required presented");
    end
    rst = 1'b1;
    step();
    checks++;
    if ({bus.rd_en, bus.out_valid, bus.busy, bus.done} !== 4'b0 || bus.rd_addr !== '0 ||
        bus.out_addr !== '0 || bus.out_data !== '0 || bus.checksum !== '0) begin
      errors++;
      $display("FAIL reset_mid_sweep: en=%b v=%b busy=%b done=%b rd_addr=%0d out_addr=%0d data=%h sum=%h required all 0",
               bus.rd_en, bus.out_valid, bus.busy, bus.done, bus.rd_addr, bus.out_addr, bus.out_data, bus.checksum);
    end
    step();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.done || bus.busy) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d cycles with done/busy after reset, required 0", bad);
    end
  endtask

  task automatic test_full_sweep();
    int n, idx, dones, done_cyc;
    logic [DW-1:0] sum;
    logic [AW-1:0] ea;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    n = cyc + 1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.rd_en !== 1'b1 || bus.rd_addr !== '0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL sweep_first_read: rd_en=%b rd_addr=%0d busy=%b required 1/0/1", bus.rd_en, bus.rd_addr, bus.busy);
    end
    idx = 0; dones = 0; done_cyc = -1; sum = '0;
    for (int k = 0; k < 150 && dones == 0; k++) begin
      if (bus.out_valid && bus.out_ready) begin
        ea = AW'(idx);
        $display("tx full addr=%0d data=%h edge=%0d", bus.out_addr, bus.out_data, cyc + 1 - n);
        checks++;
        if (bus.out_addr !== ea || bus.out_data !== regs[idx] || cyc + 1 != n + 3 * (idx + 1)) begin
          errors++;
          $display("FAIL sweep_entry[%0d]: addr=%0d data=%h edge=N+%0d required addr=%0d data=%h edge=N+%0d",
                   idx, bus.out_addr, bus.out_data, cyc + 1 - n, ea, regs[idx], 3 * (idx + 1));
        end
        sum = sum + regs[idx];
        idx++;
      end
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
        checks++;
        if (bus.checksum !== exp_sum(sum) || bus.rd_addr !== 5'd31) begin
          errors++;
          $display("FAIL sweep_checksum: checksum=%h rd_addr=%0d required %h / 31", bus.checksum, bus.rd_addr, exp_sum(sum));
        end
      end else begin
        step();
      end
    end
    checks++;
    if (idx != 32 || dones != 1 || done_cyc != n + 96) begin
      errors++;
      $display("FAIL sweep_done: entries=%0d dones=%0d done_edge=N+%0d required 32/1/N+96", idx, dones, done_cyc - n);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_idle: done=%b busy=%b after N+97 required 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int n, idx, held, dones, done_cyc;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data, sum;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    n = cyc + 1;
    step();
    bus.start = 1'b0;
    idx = 0; held = 0; dones = 0; done_cyc = -1; sum = '0;
    prev_addr = '0; prev_data = '0;
    for (int k = 0; k < 300 && dones == 0; k++) begin
      if (bus.out_valid) begin
        held++;
        if (held > 1) begin
          checks++;
          if (bus.out_addr !== prev_addr || bus.out_data !== prev_data) begin
            errors++;
            $display("FAIL bp_stable: addr=%0d data=%h required held %0d/%h", bus.out_addr, bus.out_data, prev_addr, prev_data);
          end
        end
        prev_addr = bus.out_addr;
        prev_data = bus.out_data;
        bus.out_ready = (held == 3);
        if (held == 3) begin
          $display("tx bp addr=%0d data=%h", bus.out_addr, bus.out_data);
          checks++;
          if (bus.out_addr !== AW'(idx) || bus.out_data !== regs[idx]) begin
            errors++;
            $display("FAIL bp_entry[%0d]: addr=%0d data=%h required %0d/%h", idx, bus.out_addr, bus.out_data, idx, regs[idx]);
          end
          sum = sum + regs[idx];
          idx++;
        end
      end else begin
        if (held != 0) begin
          checks++;
          if (held != 3) begin
            errors++;
            $display("FAIL bp_hold: entry presented %0d cycles, required 3", held);
          end
        end
        held = 0;
        bus.out_ready = 1'b0;
      end
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
      end else begin
        step();
      end
    end
    checks++;
    if (idx != 32 || done_cyc != n + 160 || bus.checksum !== exp_sum(sum)) begin
      errors++;
      $display("FAIL bp_done: entries=%0d done_edge=N+%0d checksum=%h required 32/N+160/%h", idx, done_cyc - n, bus.checksum, exp_sum(sum));
    end
    step();
  endtask

  task automatic test_random_ready();
    int n, idx, stalls, done_cyc;
    logic [DW-1:0] sum;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    n = cyc + 1;
    step();
    bus.start = 1'b0;
    idx = 0; stalls = 0; done_cyc = -1; sum = '0;
    for (int k = 0; k < 400 && done_cyc < 0; k++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && !bus.out_ready) stalls++;
      if (bus.out_valid && bus.out_ready) begin
        $display("tx rnd addr=%0d data=%h stalls=%0d", bus.out_addr, bus.out_data, stalls);
        checks++;
        if (bus.out_addr !== AW'(idx) || bus.out_data !== regs[idx] || cyc + 1 != n + 3 * (idx + 1) + stalls) begin
          errors++;
          $display("FAIL rnd_entry[%0d]: addr=%0d data=%h edge=N+%0d required %0d/%h/N+%0d",
                   idx, bus.out_addr, bus.out_data, cyc + 1 - n, idx, regs[idx], 3 * (idx + 1) + stalls);
        end
        sum = sum + regs[idx];
        idx++;
      end
      if (bus.done) done_cyc = cyc;
      else step();
    end
    checks++;
    if (idx != 32 || done_cyc != n + 96 + stalls || bus.checksum !== exp_sum(sum)) begin
      errors++;
      $display("FAIL rnd_done: entries=%0d done_edge=N+%0d checksum=%h required 32/N+%0d/%h",
               idx, done_cyc - n, bus.checksum, 96 + stalls, exp_sum(sum));
    end
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic test_abort();
    int n, found, bad;
    logic [DW-1:0] sum;
    for (int i = 0; i < 32; i++) regs[i] = 32'h2000_0000 + (i * 7);
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    found = 0; sum = '0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (bus.out_valid && bus.out_addr == 5'd5) begin
        found = 1;
        bus.abort = 1'b1;
      end else begin
        if (bus.out_valid && bus.out_ready) sum = sum + regs[bus.out_addr];
        step();
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_reach: addr 5 not presented within 60 cycles, required presented");
    end
    step();
    bus.abort = 1'b0;
    checks++;
    if ({bus.out_valid, bus.rd_en, bus.busy, bus.done} !== 4'b0 || bus.checksum !== exp_sum(sum)) begin
      errors++;
      $display("FAIL abort_idle: valid/en/busy/done=%b checksum=%h required 0000/%h",
               {bus.out_valid, bus.rd_en, bus.busy, bus.done}, bus.checksum, exp_sum(sum));
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done || bus.busy || bus.out_valid) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d active cycles after abort, required 0", bad);
    end
    bus.start = 1'b1;
    n = cyc + 1;
    step();
    bus.start = 1'b0;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== '0 || bus.out_data !== regs[0] || cyc != n + 2) begin
      errors++;
      $display("FAIL abort_restart: valid=%b addr=%0d data=%h at N+%0d required 1/0/%h at N+2",
               bus.out_valid, bus.out_addr, bus.out_data, cyc - n, regs[0]);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    step();
  endtask

  task automatic test_start_held();
    int n, hs, dones, done_cyc;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    n = cyc + 1;
    step();
    hs = 0; dones = 0; done_cyc = -1;
    for (int k = 0; k < 120 && cyc < n + 98; k++) begin
      if (bus.out_valid && bus.out_ready) hs++;
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
      end
      if (cyc == n + 97) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
          errors++;
          $display("FAIL held_gap: busy=%b rd_en=%b at N+97 required 0/0", bus.busy, bus.rd_en);
        end
      end
      step();
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.rd_en !== 1'b1 || bus.rd_addr !== '0 || cyc != n + 98) begin
      errors++;
      $display("FAIL held_restart: busy=%b rd_en=%b rd_addr=%0d at N+%0d required 1/1/0 at N+98",
               bus.busy, bus.rd_en, bus.rd_addr, cyc - n);
    end
    checks++;
    if (hs != 32 || dones != 1 || done_cyc != n + 96) begin
      errors++;
      $display("FAIL held_single: entries=%0d dones=%0d done_edge=N+%0d required 32/1/N+96", hs, dones, done_cyc - n);
    end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    step();
  endtask

  task automatic test_checksum();
    int n, idx, bad, done_cyc;
    logic [DW-1:0] sum;
    regs[1] = 32'hFFFF_FFFF;
    regs[2] = 32'd1;
    regs[3] = 32'd2;
    regs[4] = 32'd3;
    bus2.out_ready = 1'b1;
    bus2.start = 1'b1;
    n = cyc + 1;
    step();
    bus2.start = 1'b0;
    checks++;
    if (bus2.rd_en !== 1'b1 || bus2.rd_addr !== 5'd1) begin
      errors++;
      $display("FAIL cks_first: rd_en=%b rd_addr=%0d required 1/1", bus2.rd_en, bus2.rd_addr);
    end
    idx = 0; bad = 0; done_cyc = -1; sum = '0;
    for (int k = 0; k < 40 && done_cyc < 0; k++) begin
      if (bus2.checksum !== exp_sum(sum)) bad++;
      if (bus2.out_valid && bus2.out_ready) begin
        $display("tx cks addr=%0d data=%h", bus2.out_addr, bus2.out_data);
        checks++;
        if (bus2.out_addr !== AW'(idx + 1) || bus2.out_data !== regs[idx + 1]) begin
          errors++;
          $display("FAIL cks_entry[%0d]: addr=%0d data=%h required %0d/%h", idx, bus2.out_addr, bus2.out_data, idx + 1, regs[idx + 1]);
        end
        sum = sum + regs[idx + 1];
        idx++;
      end
      if (bus2.done) done_cyc = cyc;
      else step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cks_running: %0d cycles with wrong running checksum, required 0", bad);
    end
    checks++;
    if (bus2.checksum !== exp_sum(32'h0000_0005) || bus2.rd_addr !== 5'd4 || idx != 4 || done_cyc != n + 12) begin
      errors++;
      $display("FAIL cks_done: checksum=%h rd_addr=%0d entries=%0d done_edge=N+%0d required %h/4/4/N+12",
               bus2.checksum, bus2.rd_addr, idx, done_cyc - n, exp_sum(32'h0000_0005));
    end
    step();
  endtask

  initial begin
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.out_ready = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_random_ready();
    test_abort();
    test_start_held();
    test_checksum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
